// File: rtl/phys_reg_file_sb.sv
// Physical register file with ready-bit scoreboard, registered read with write bypass, hardwired-zero p0.
// Optional PRF_RESET_DATA_EN: reset also clears every storage entry (default: only p0 is cleared).
module phys_reg_file_sb #(
  parameter int READ_PORT_NUM  = 4,
  parameter int WRITE_PORT_NUM = 2,
  parameter int ALLOC_PORT_NUM = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int PHY_REG_NUM    = 64,
  localparam int AW            = $clog2(PHY_REG_NUM)
) (
  input  logic                                       clk,
  input  logic                                       s_rst_n,
  input  logic [READ_PORT_NUM-1:0]                   re_i,
  input  logic [READ_PORT_NUM-1:0][AW-1:0]           raddr_i,
  output logic [READ_PORT_NUM-1:0][DATA_WIDTH-1:0]   data_o,
  output logic [READ_PORT_NUM-1:0]                   rdy_o,
  input  logic [WRITE_PORT_NUM-1:0]                  we_i,
  input  logic [WRITE_PORT_NUM-1:0][AW-1:0]          waddr_i,
  input  logic [WRITE_PORT_NUM-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [ALLOC_PORT_NUM-1:0]                  alloc_i,
  input  logic [ALLOC_PORT_NUM-1:0][AW-1:0]          alloc_addr_i,
  output logic [AW:0]                                busy_cnt_o
);

  logic [DATA_WIDTH-1:0]                     storage_q [PHY_REG_NUM];
  logic [DATA_WIDTH-1:0]                     storage_d [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0]                    ready_q, ready_d;
  logic [READ_PORT_NUM-1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic [AW:0]                               busy_q, busy_d;

  // Ascending port order makes the highest-index write win; allocates applied after writes win over them.
  always_comb begin
    storage_d = storage_q;
    ready_d   = ready_q;
    for (int unsigned j = 0; j < WRITE_PORT_NUM; j++) begin
      if (we_i[j] && waddr_i[j] != '0) begin
        storage_d[waddr_i[j]] = wdata_i[j];
        ready_d[waddr_i[j]]   = 1'b1;
      end
    end
    for (int unsigned k = 0; k < ALLOC_PORT_NUM; k++) begin
      if (alloc_i[k] && alloc_addr_i[k] != '0) begin
        ready_d[alloc_addr_i[k]] = 1'b0;
      end
    end
    ready_d[0] = 1'b1;
  end

  always_comb begin
    data_d = '0;
    for (int unsigned i = 0; i < READ_PORT_NUM; i++) begin
      if (re_i[i] && raddr_i[i] != '0) begin
        data_d[i] = storage_d[raddr_i[i]];
      end
    end
  end

  always_comb begin
    rdy_o = '0;
    for (int unsigned i = 0; i < READ_PORT_NUM; i++) begin
      rdy_o[i] = ready_q[raddr_i[i]];
      for (int unsigned j = 0; j < WRITE_PORT_NUM; j++) begin
        if (we_i[j] && waddr_i[j] == raddr_i[i] && raddr_i[i] != '0) begin
          rdy_o[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_d = '0;
    for (int unsigned k = 0; k < PHY_REG_NUM; k++) begin
      busy_d = busy_d + {{AW{1'b0}}, ~ready_q[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      ready_q <= '1;
      data_q  <= '0;
      busy_q  <= '0;
`ifdef PRF_RESET_DATA_EN
      for (int unsigned k = 0; k < PHY_REG_NUM; k++) begin
        storage_q[k] <= '0;
      end
`else
      storage_q[0] <= '0;
`endif
    end else begin
      storage_q <= storage_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  assign data_o     = data_q;
  assign busy_cnt_o = busy_q;

endmodule

// File: tb/tb_phys_reg_file_sb.sv
// Randomized self-checking bench for phys_reg_file_sb against an array-based reference model.
module tb_phys_reg_file_sb;

  localparam int RP = 4, WP = 2, AP = 2, DW = 32, NR = 64, AW = 6;

  logic                     clk = 1'b0;
  logic                     s_rst_n;
  logic [RP-1:0]            re;
  logic [RP-1:0][AW-1:0]    raddr;
  logic [RP-1:0][DW-1:0]    data_o;
  logic [RP-1:0]            rdy_o;
  logic [WP-1:0]            we;
  logic [WP-1:0][AW-1:0]    waddr;
  logic [WP-1:0][DW-1:0]    wdata;
  logic [AP-1:0]            alloc;
  logic [AP-1:0][AW-1:0]    alloc_addr;
  logic [AW:0]              busy_cnt;

  phys_reg_file_sb #(
    .READ_PORT_NUM(RP), .WRITE_PORT_NUM(WP), .ALLOC_PORT_NUM(AP),
    .DATA_WIDTH(DW), .PHY_REG_NUM(NR)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .re_i(re), .raddr_i(raddr), .data_o(data_o), .rdy_o(rdy_o),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .busy_cnt_o(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, which contents are defined, and scoreboard bits.
  logic [DW-1:0] mem_m [NR];
  bit            known_m [NR];
  bit            rdy_m [NR];
  logic [DW-1:0] exp_d [RP];
  bit            exp_k [RP];
  int            exp_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst_n = 1'b1; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    alloc = '0; alloc_addr = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit r;
    int cnt;
    #1;
    for (int i = 0; i < RP; i++) begin
      r = rdy_m[raddr[i]];
      for (int j = 0; j < WP; j++)
        if (we[j] && waddr[j] == raddr[i] && raddr[i] != 0) r = 1'b1;
      check($sformatf("rdy[%0d]@p%0d", i, raddr[i]), {63'd0, rdy_o[i]}, {63'd0, r});
    end
    if (!s_rst_n) begin
      exp_busy = 0;
      for (int k = 0; k < NR; k++) begin
        rdy_m[k] = 1'b1;
`ifdef PRF_RESET_DATA_EN
        mem_m[k] = '0; known_m[k] = 1'b1;
`endif
      end
      mem_m[0] = '0; known_m[0] = 1'b1;
      for (int i = 0; i < RP; i++) begin exp_d[i] = '0; exp_k[i] = 1'b1; end
    end else begin
      cnt = 0;
      for (int k = 0; k < NR; k++) if (!rdy_m[k]) cnt++;
      exp_busy = cnt;
      for (int j = 0; j < WP; j++)
        if (we[j] && waddr[j] != 0) begin
          mem_m[waddr[j]] = wdata[j]; known_m[waddr[j]] = 1'b1; rdy_m[waddr[j]] = 1'b1;
        end
      for (int k = 0; k < AP; k++)
        if (alloc[k] && alloc_addr[k] != 0) rdy_m[alloc_addr[k]] = 1'b0;
      for (int i = 0; i < RP; i++) begin
        if (!re[i] || raddr[i] == 0) begin exp_d[i] = '0; exp_k[i] = 1'b1; end
        else begin exp_d[i] = mem_m[raddr[i]]; exp_k[i] = known_m[raddr[i]]; end
      end
    end
    @(negedge clk);
    for (int i = 0; i < RP; i++)
      if (exp_k[i]) check($sformatf("data[%0d]", i), {32'd0, data_o[i]}, {32'd0, exp_d[i]});
    check("busy_cnt", {57'd0, busy_cnt}, 64'(exp_busy));
  endtask

  task automatic sweep_rdy();
    for (int b = 0; b < NR; b += RP) begin
      idle();
      re = '1;
      for (int i = 0; i < RP; i++) raddr[i] = AW'(b + i);
      step();
    end
  endtask

  initial begin
    idle();
    s_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      rdy_m[k] = 1'b1;
`ifdef PRF_RESET_DATA_EN
      known_m[k] = 1'b1;
`else
      known_m[k] = 1'b0;
`endif
      mem_m[k] = '0;
    end
    known_m[0] = 1'b1;
    for (int i = 0; i < RP; i++) begin exp_d[i] = '0; exp_k[i] = 1'b1; end
    exp_busy = 0;
    s_rst_n = 1'b1;
    check("reset_data0", {32'd0, data_o[0]}, 64'd0);
    check("reset_busy", {57'd0, busy_cnt}, 64'd0);
    sweep_rdy();

    // Allocate p5, observe busy, then write and read it back.
    idle(); alloc[0] = 1'b1; alloc_addr[0] = 6'd5; step();
    idle(); re[0] = 1'b1; raddr[0] = 6'd5; step();
    check("p5_busy", {57'd0, busy_cnt}, 64'd1);
    idle(); step();
    idle(); re[0] = 1'b1; raddr[0] = 6'd5; we[0] = 1'b1; waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF; step();
    check("p5_data", {32'd0, data_o[0]}, 64'hDEADBEEF);

    // Dual write to p7: higher port wins.
    idle(); we = 2'b11; waddr[0] = 6'd7; waddr[1] = 6'd7; wdata[0] = 32'h11; wdata[1] = 32'h22; step();
    idle(); re[1] = 1'b1; raddr[1] = 6'd7; step();
    check("p7_dual", {32'd0, data_o[1]}, 64'h22);

    // Allocate and write p9 together: data lands, register stays busy.
    idle(); alloc[1] = 1'b1; alloc_addr[1] = 6'd9; we[1] = 1'b1; waddr[1] = 6'd9; wdata[1] = 32'h33; step();
    idle(); re[2] = 1'b1; raddr[2] = 6'd9; step();
    check("p9_data", {32'd0, data_o[2]}, 64'h33);

    // p0 ignores writes and allocates.
    idle(); we[0] = 1'b1; waddr[0] = '0; wdata[0] = '1; alloc[0] = 1'b1; alloc_addr[0] = '0; step();
    idle(); re[3] = 1'b1; raddr[3] = '0; step();
    check("p0_data", {32'd0, data_o[3]}, 64'd0);

    // Reset mid-operation with a write in flight.
    idle(); alloc = 2'b11; alloc_addr[0] = 6'd3; alloc_addr[1] = 6'd4; we[0] = 1'b1; waddr[0] = 6'd10; wdata[0] = 32'h55; step();
    idle(); s_rst_n = 1'b0; we[1] = 1'b1; waddr[1] = 6'd10; wdata[1] = 32'h99; alloc[0] = 1'b1; alloc_addr[0] = 6'd11; step();
    check("rst_busy", {57'd0, busy_cnt}, 64'd0);
    sweep_rdy();
    idle(); re[0] = 1'b1; raddr[0] = 6'd10; step();
`ifdef PRF_RESET_DATA_EN
    check("p10_after_rst", {32'd0, data_o[0]}, 64'd0);
`else
    check("p10_after_rst", {32'd0, data_o[0]}, 64'h55);
`endif

    // Random traffic over a narrow address window to force collisions.
    for (int c = 0; c < 600; c++) begin
      s_rst_n = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < RP; i++) begin
        re[i] = $urandom_range(0, 3) != 0; raddr[i] = AW'($urandom_range(0, 15));
      end
      for (int j = 0; j < WP; j++) begin
        we[j] = $urandom_range(0, 1); waddr[j] = AW'($urandom_range(0, 15)); wdata[j] = $urandom;
      end
      for (int k = 0; k < AP; k++) begin
        alloc[k] = $urandom_range(0, 1); alloc_addr[k] = AW'($urandom_range(0, 15));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
